axi_spy_drain_arbiter: RTL
==========================

Name: axi_spy_drain_arbiter

Overview:
- Drains the four AXI spy-block capture FIFOs (R, AR, W, AW) onto one serial readout stream.
- Each entry is tagged with its source channel and a running sequence number.
- Sits between the spy FIFOs' pop/empty/pop-data ports and the debug readout logic.
- Arbitration is round-robin so that no channel starves. Only this block pops the FIFOs during normal operation.

Parameters:
- DATA_WIDTH, 32: width of every spy FIFO entry and of out_data.
- SEQ_WIDTH, 8: width of the sequence counter out_seq.
- CNT_WIDTH, 16: width of the total-transfer counter xfer_count.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_i  input  1  allows new arbitration rounds.
- fifo_empty_i  input  4  empty flags; bit 0=R, 1=AR, 2=W, 3=AW.
- fifo_data_i  input  4*DATA_WIDTH  pop data; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- fifo_pop_o  output  4  one-hot pop strobes to the FIFOs.
- out_valid_o  output  1  readout entry valid.
- out_ready_i  input  1  readout sink accepts the entry.
- out_data_o  output  DATA_WIDTH  captured entry.
- out_chan_o  output  2  source channel index of the entry.
- out_seq_o  output  SEQ_WIDTH  sequence number of the entry.
- busy_o  output  1  high whenever the state is not IDLE.
- xfer_count_o  output  CNT_WIDTH  total entries accepted by the sink.

Behaviour:
- Reset values:
  - fifo_pop_o=0, out_valid_o=0, out_data_o=0, out_chan_o=0, out_seq_o=0, busy_o=0, xfer_count_o=0.
  - Round-robin pointer rr=0; state=IDLE.
- FIFO contract: pop data is registered. fifo_data_i for channel c is valid in the cycle after fifo_pop_o[c] is sampled high.
- FSM states: IDLE, POP, LOAD, SEND.
- IDLE:
  - If enable_i=1 and any fifo_empty_i bit is 0, grant the first non-empty channel searching rr, rr+1, ... (mod 4).
  - Register the grant and go to POP. Otherwise stay in IDLE.
- POP:
  - fifo_pop_o = one-hot(grant) for exactly this one cycle. Go to LOAD.
  - fifo_pop_o is 0 in every other state.
- LOAD:
  - out_data_o <= fifo_data_i[grant], out_chan_o <= grant. Go to SEND.
- SEND:
  - out_valid_o=1. out_data_o, out_chan_o and out_seq_o are held stable until the sink accepts.
  - On out_valid_o & out_ready_i:
    - out_seq_o increments, wrapping at 2^SEQ_WIDTH.
    - xfer_count_o increments, wrapping at 2^CNT_WIDTH.
    - rr <= grant+1 (mod 4); go to IDLE.
  - out_valid_o drops in the cycle after acceptance.
- Latency: the first IDLE cycle with a non-empty FIFO is cycle T. Pop is at T+1, out_valid_o at T+3. With out_ready_i held high, the minimum period is 4 cycles per entry.
- Boundary conditions:
  - enable_i deasserted mid-transfer: the current entry completes through SEND; no new grant is made while enable_i=0.
  - Empty flag changes after the grant: ignored; the pop is already committed.
  - All FIFOs empty: stay in IDLE; no pop is issued.
  - out_ready_i high outside SEND: ignored.
  - Reset mid-operation: immediate return to reset values. A captured but unsent entry is discarded, and no pop is issued in the reset cycle.
  - Spy-block overflow self-pops may race the drain; the arbiter does not detect this. Software uses out_seq_o gaps versus FIFO depth for diagnosis.

Test Plan:
- Reset, then only R FIFO non-empty with data 0xDEAD_0001, out_ready_i=1: fifo_pop_o=0001 at T+1, out_valid_o at T+3 with data 0xDEAD_0001, out_chan_o=0, out_seq_o=0; xfer_count_o=1 afterwards.
- All four FIFOs continuously non-empty, out_ready_i=1, 8 transfers: out_chan_o sequence 0,1,2,3,0,1,2,3; out_seq_o 0..7; one entry every 4 cycles.
- out_ready_i held low 10 cycles in SEND: out_valid_o stays 1, data/chan/seq stable, no further pops. Raise ready: accepted in that cycle, out_valid_o=0 the next cycle.
- Only AW and AR non-empty, rr=0: grants AR (1) then AW (3), then AR again, never W or R.
- enable_i dropped during POP: the entry still appears and is accepted; then busy_o=0 and no pops while enable_i=0 even with FIFOs non-empty.
- Reset asserted during SEND with out_seq_o=5: next cycle all outputs are 0 and the state is IDLE; the next transfer carries out_seq_o=0 and out_chan_o is chosen from rr=0.

Source files
------------

// File: rtl/axi_spy_drain_arbiter.sv
// Round-robin drain of the four AXI spy capture FIFOs (R, AR, W, AW) onto one
// serial readout stream; each entry is tagged with its channel and a sequence number.
module axi_spy_drain_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SEQ_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable_i,
   input  logic [3:0]              fifo_empty_i,
   input  logic [4*DATA_WIDTH-1:0] fifo_data_i,
   output logic [3:0]              fifo_pop_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   output logic [1:0]              out_chan_o,
   output logic [SEQ_WIDTH-1:0]    out_seq_o,
   output logic                    busy_o,
   output logic [CNT_WIDTH-1:0]    xfer_count_o
);

   localparam int unsigned NUM_CH = 4;

   typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_e;

   state_e                state_q, state_d;
   logic [1:0]            rr_q, rr_d;
   logic [1:0]            grant_q, grant_d;
   logic [3:0]            pop_q, pop_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            chan_q, chan_d;
   logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
   logic                  busy_q, busy_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  found_c;
   logic [1:0]            pick_c;

   // First non-empty channel starting at the round-robin pointer
   always_comb begin
      found_c = 1'b0;
      pick_c  = rr_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!found_c && !fifo_empty_i[2'(rr_q + 2'(i))]) begin
            found_c = 1'b1;
            pick_c  = 2'(rr_q + 2'(i));
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      pop_d   = '0;
      valid_d = valid_q;
      data_d  = data_q;
      chan_d  = chan_q;
      seq_d   = seq_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            if (enable_i && found_c) begin
               grant_d = pick_c;
               pop_d   = 4'(1) << pick_c;
               state_d = POP;
            end
         end
         POP: begin
            state_d = LOAD;
         end
         LOAD: begin
            // FIFO pop data is registered, so it lands one cycle after the strobe
            data_d  = fifo_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
            chan_d  = grant_q;
            valid_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (valid_q && out_ready_i) begin
               valid_d = 1'b0;
               seq_d   = seq_q + SEQ_WIDTH'(1);
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               rr_d    = grant_q + 2'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         pop_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
         seq_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         pop_q   <= pop_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         chan_q  <= chan_d;
         seq_q   <= seq_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fifo_pop_o   = pop_q;
   assign out_valid_o  = valid_q;
   assign out_data_o   = data_q;
   assign out_chan_o   = chan_q;
   assign out_seq_o    = seq_q;
   assign busy_o       = busy_q;
   assign xfer_count_o = cnt_q;

endmodule
